// File: rtl/dongwon_cache_ctrl.sv
// dongwon_cache_ctrl
//   Direct-mapped, write-through, no-write-allocate cache controller between a
//   CPU-side requester and dongwon_ram. Read misses are refilled by the
//   controller itself from the RAM read data.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   CPU request; held stable until cpu_ready
//   cpu_rdata, cpu_ready    read data and one-cycle completion pulse
//   mem_run/we/addr/wdata   RAM command
//   mem_rdata               RAM read data
//   state_of_cache          current FSM state code
//
// Optional build macro
//   DONGWON_CACHE_STAT_EN   adds saturating hit_cnt / miss_cnt outputs
module dongwon_cache_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CACHE_SIZE  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  mem_run,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [2:0]            state_of_cache
`ifdef DONGWON_CACHE_STAT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int IDX_W = $clog2(CACHE_SIZE);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_WRITE     = 3'b010,
        S_READ_MISS = 3'b100,
        S_READ_HIT  = 3'b101,
        S_REFILL    = 3'b110
    } state_t;

    state_t state_q, state_d;

    logic [CACHE_SIZE-1:0] valid_q;
    logic [TAG_W-1:0]      tag_mem  [CACHE_SIZE];
    logic [DATA_WIDTH-1:0] data_mem [CACHE_SIZE];

    logic [CNT_W-1:0]      lat_cnt;
    logic                  req_hit_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  ready_d, run_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;

    // Lookup on the live CPU address (used only while sampling in IDLE).
    logic [IDX_W-1:0] in_idx;
    logic [TAG_W-1:0] in_tag;
    logic             lookup_hit;

    assign in_idx     = cpu_addr[2 +: IDX_W];
    assign in_tag     = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign lookup_hit = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);

    // mem_addr / mem_wdata are loaded when the request is sampled and stay
    // put for the whole transaction, so they double as the request latch.
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    assign req_idx = mem_addr[2 +: IDX_W];
    assign req_tag = mem_addr[ADDR_WIDTH-1 -: TAG_W];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (!cpu_req)       state_d = S_IDLE;
                else if (cpu_we)    state_d = S_WRITE;
                else if (lookup_hit) state_d = S_READ_HIT;
                else                state_d = S_READ_MISS;
            end
            S_READ_MISS: state_d = (lat_cnt == '0) ? S_REFILL : S_READ_MISS;
            default:     state_d = S_IDLE;  // WRITE, READ_HIT, REFILL, illegal codes
        endcase
    end

    // ---------------- output logic (values registered below) ----------------
    always_comb begin
        ready_d = (state_d == S_READ_HIT) || (state_d == S_WRITE) || (state_d == S_REFILL);
        run_d   = (state_d == S_READ_MISS) || (state_d == S_WRITE);
        we_d    = (state_d == S_WRITE);
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        rdata_d = rdata_q;
        if (state_q == S_IDLE && cpu_req) begin
            addr_d = cpu_addr;
            if (cpu_we) wdata_d = cpu_wdata;
        end
        if (state_d == S_READ_HIT) rdata_d = data_mem[in_idx];
        if (state_q == S_REFILL)   rdata_d = mem_rdata;  // keep refill data after ready
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ready <= 1'b0;
            mem_run   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            cpu_ready <= ready_d;
            mem_run   <= run_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // RAM data only becomes valid in the REFILL cycle itself, so the refill
    // word is forwarded straight from the RAM's output register there.
    assign cpu_rdata      = (state_q == S_REFILL) ? mem_rdata : rdata_q;
    assign state_of_cache = state_q;

    // ---------------- control datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            lat_cnt   <= '0;
            req_hit_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                lat_cnt   <= CNT_W'(MEM_LATENCY - 1);
                req_hit_q <= lookup_hit;
            end else if (state_q == S_READ_MISS && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (state_q == S_REFILL) valid_q[req_idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state_q == S_REFILL) begin
            data_mem[req_idx] <= mem_rdata;
            tag_mem[req_idx]  <= req_tag;
        end else if (state_q == S_WRITE && req_hit_q) begin
            data_mem[req_idx] <= mem_wdata;  // write hit; misses do not allocate
        end
    end

`ifdef DONGWON_CACHE_STAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == S_IDLE) begin
            if (state_d == S_READ_HIT && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (state_d == S_READ_MISS && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dongwon_cache_ctrl.sv
// Directed bench for dongwon_cache_ctrl. Instance 0 runs with MEM_LATENCY=1,
// instance 1 with MEM_LATENCY=3 (reset-during-miss scenario). Each instance
// has a small behavioural RAM model.
module tb_dongwon_cache_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [2];
    logic        req    [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        ready  [2];
    logic        run    [2];
    logic        mwe    [2];
    logic [31:0] maddr  [2];
    logic [31:0] mwdata [2];
    logic [2:0]  st     [2];
    logic [31:0] mrd0, mrd1;
`ifdef DONGWON_CACHE_STAT_EN
    logic [31:0] hc [2];
    logic [31:0] mc [2];
`endif

    dongwon_cache_ctrl #(.MEM_LATENCY(1)) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]), .cpu_req(req[0]), .cpu_we(we[0]),
        .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_rdata(rdata[0]),
        .cpu_ready(ready[0]), .mem_run(run[0]), .mem_we(mwe[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrd0),
        .state_of_cache(st[0])
`ifdef DONGWON_CACHE_STAT_EN
        , .hit_cnt(hc[0]), .miss_cnt(mc[0])
`endif
    );

    dongwon_cache_ctrl #(.MEM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset_n(rst_n[1]), .cpu_req(req[1]), .cpu_we(we[1]),
        .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_rdata(rdata[1]),
        .cpu_ready(ready[1]), .mem_run(run[1]), .mem_we(mwe[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrd1),
        .state_of_cache(st[1])
`ifdef DONGWON_CACHE_STAT_EN
        , .hit_cnt(hc[1]), .miss_cnt(mc[1])
`endif
    );

    // RAM models: 1024 words, word index = addr[11:2]
    logic [31:0] ram0 [1024];
    logic [31:0] ram1 [1024];
    logic [31:0] p1, p2;

    always @(posedge clk) begin
        if (run[0]) begin
            if (mwe[0]) ram0[maddr[0][11:2]] <= mwdata[0];
            else        mrd0 <= ram0[maddr[0][11:2]];
        end
    end

    // three-stage read pipe for the latency-3 instance
    always @(posedge clk) begin
        p1   <= ram1[maddr[1][11:2]];
        p2   <= p1;
        mrd1 <= p2;
        if (run[1] && mwe[1]) ram1[maddr[1][11:2]] <= mwdata[1];
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // results of the last request
    logic [31:0] r_rdata, r_maddr, r_mwdata;
    logic        r_mwe, r_run;
    logic [7:0]  r_seen;
    int          r_lat;

    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done = 0;
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        r_lat = 0; r_seen = '0; r_run = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); r_lat++;
            @(negedge clk);
            r_seen[st[d]] = 1'b1;
            if (run[d]) r_run = 1'b1;
            if (ready[d]) begin
                done     = 1;
                r_rdata  = rdata[d];
                r_maddr  = maddr[d];
                r_mwe    = mwe[d];
                r_mwdata = mwdata[d];
            end
        end
        if (!done) chk("ready_timeout", 64'(r_lat), 64'(0));
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    initial begin
        int pulses;
        bit found;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        for (int i = 0; i < 1024; i++) begin
            ram0[i] = (i < 32) ? 32'(i) : 32'h0;
            ram1[i] = 32'h0;
        end
        ram0[64] = 32'hC0FF_EE40;
        ram1[8]  = 32'hA5A5_0008;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(st[0]), 64'(3'b000));
        chk("rst_ready", 64'(ready[0]), 64'(0));
        chk("rst_run",   64'(run[0]), 64'(0));
        chk("rst_we",    64'(mwe[0]), 64'(0));
        chk("rst_rdata", 64'(rdata[0]), 64'(0));
        chk("rst_maddr", 64'(maddr[0]), 64'(0));
        chk("rst_mwdata", 64'(mwdata[0]), 64'(0));
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // first read after reset: miss, refill, no hit state
        do_req(0, 1'b0, 32'h0, 32'h0);
        chk("first_rdata", 64'(r_rdata), 64'(0));
        chk("first_lat",   64'(r_lat), 64'(2));
        chk("first_nohit", 64'(r_seen[5]), 64'(0));
        chk("first_miss",  64'(r_seen[4]), 64'(1));
        chk("first_refill", 64'(r_seen[6]), 64'(1));

        // fill pass (all misses) then reread pass (all hits)
        do_reset(0);
        for (int i = 0; i < 32; i++) begin
            do_req(0, 1'b0, 32'(i * 4), 32'h0);
            chk("p1_rdata", 64'(r_rdata), 64'(i));
            chk("p1_lat",   64'(r_lat), 64'(2));
        end
        for (int i = 0; i < 32; i++) begin
            do_req(0, 1'b0, 32'(i * 4), 32'h0);
            chk("p2_rdata", 64'(r_rdata), 64'(i));
            chk("p2_lat",   64'(r_lat), 64'(1));
            chk("p2_run",   64'(r_run), 64'(0));
            chk("p2_hit",   64'(r_seen[5]), 64'(1));
        end

        // write hit
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        chk("wh_state",  64'(r_seen[2]), 64'(1));
        chk("wh_mwe",    64'(r_mwe), 64'(1));
        chk("wh_maddr",  64'(r_maddr), 64'h10);
        chk("wh_mwdata", 64'(r_mwdata), 64'hDEAD_BEEF);
        chk("wh_lat",    64'(r_lat), 64'(1));
        chk("wh_ram",    64'(ram0[4]), 64'hDEAD_BEEF);
        do_req(0, 1'b0, 32'h10, 32'h0);
        chk("wh_rd_lat",   64'(r_lat), 64'(1));
        chk("wh_rd_rdata", 64'(r_rdata), 64'hDEAD_BEEF);

        // write miss: RAM written, no allocate
        do_req(0, 1'b1, 32'h200, 32'h1234);
        chk("wm_maddr", 64'(r_maddr), 64'h200);
        chk("wm_ram",   64'(ram0[128]), 64'h1234);
        do_req(0, 1'b0, 32'h200, 32'h0);
        chk("wm_rd_lat",   64'(r_lat), 64'(2));
        chk("wm_rd_rdata", 64'(r_rdata), 64'h1234);

        // conflict misses on index 0
        do_reset(0);
        do_req(0, 1'b0, 32'h0, 32'h0);
        chk("cf0_lat", 64'(r_lat), 64'(2));
        chk("cf0_rdata", 64'(r_rdata), 64'(0));
        do_req(0, 1'b0, 32'h100, 32'h0);
        chk("cf1_lat", 64'(r_lat), 64'(2));
        chk("cf1_rdata", 64'(r_rdata), 64'hC0FF_EE40);
        do_req(0, 1'b0, 32'h0, 32'h0);
        chk("cf2_lat", 64'(r_lat), 64'(2));
        chk("cf2_rdata", 64'(r_rdata), 64'(0));
`ifdef DONGWON_CACHE_STAT_EN
        chk("cf_miss_cnt", 64'(mc[0]), 64'(3));
        chk("cf_hit_cnt",  64'(hc[0]), 64'(0));
`endif

        // latency-3 instance: normal miss, then hit
        do_req(1, 1'b0, 32'h20, 32'h0);
        chk("l3_lat",   64'(r_lat), 64'(4));
        chk("l3_rdata", 64'(r_rdata), 64'hA5A5_0008);
        do_req(1, 1'b0, 32'h20, 32'h0);
        chk("l3_hit_lat", 64'(r_lat), 64'(1));

        // reset asserted in the middle of a miss
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (st[1] == 3'b100) found = 1;
        end
        chk("rm_in_miss", 64'(found), 64'(1));
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("rm_state", 64'(st[1]), 64'(3'b000));
        chk("rm_run",   64'(run[1]), 64'(0));
        chk("rm_ready", 64'(ready[1]), 64'(0));
        req[1] = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready[1]) pulses++;
        end
        chk("rm_no_ready", 64'(pulses), 64'(0));
        rst_n[1] = 1'b1;
        do_req(1, 1'b0, 32'h20, 32'h0);
        chk("rm_after_lat",   64'(r_lat), 64'(4));
        chk("rm_after_miss",  64'(r_seen[4]), 64'(1));
        chk("rm_after_rdata", 64'(r_rdata), 64'hA5A5_0008);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dongwon_cache_ctrl.md
Name: dongwon_cache_ctrl

Overview:
Direct-mapped, write-through cache controller between the CPU-side requester and dongwon_ram. Serves CPU read/write requests from an internal tag/data array. On a read miss it initiates the RAM read and refills the line itself, so the bench/CPU no longer copies RAM data into the cache. It drives the RAM's run/we/addr/in_data and consumes its out_data.

Parameters:
ADDR_WIDTH, 32, byte address width; bits [1:0] ignored (word access only)
DATA_WIDTH, 32, word width
CACHE_SIZE, 64, number of one-word lines; power of 2, >=2
MEM_LATENCY, 1, cycles from mem_run (we=0) sampled to mem_rdata valid; >=1

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
cpu_req  input  1  request valid; held high until cpu_ready
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  input  ADDR_WIDTH  request byte address; stable while cpu_req
cpu_wdata  input  DATA_WIDTH  write data
cpu_rdata  output  DATA_WIDTH  read data, valid when cpu_ready and read
cpu_ready  output  1  one-cycle completion pulse
mem_run  output  1  RAM enable
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data
state_of_cache  output  3  current FSM state code

Behaviour:
- Reset (async, reset_n=0): all valid bits cleared, state IDLE; cpu_ready, mem_run, mem_we = 0; cpu_rdata, mem_addr, mem_wdata = 0. In-flight transaction dropped; CPU must reissue.
- Address split: index = cpu_addr[2 +: log2(CACHE_SIZE)]; tag = cpu_addr[ADDR_WIDTH-1 : 2+log2(CACHE_SIZE)]. Hit = valid[index] && tag match.
- FSM codes: IDLE 3'b000, WRITE 3'b010, READ_MISS 3'b100, READ_HIT 3'b101, REFILL 3'b110. state_of_cache = current state register.
- IDLE: cpu_req=0 -> stay. cpu_req=1, cpu_we=1 -> WRITE. cpu_req=1, cpu_we=0, hit -> READ_HIT. cpu_req=1, cpu_we=0, miss -> READ_MISS. All outputs are registered.
- READ_HIT (1 cycle): cpu_ready=1, cpu_rdata = line data, mem_run=0 -> IDLE. Latency: ready 1 cycle after request sampled.
- READ_MISS: mem_run=1, mem_we=0, mem_addr=cpu_addr, held for MEM_LATENCY cycles (internal down-counter) -> REFILL.
- REFILL (1 cycle): mem_rdata captured into data[index], tag stored, valid set; cpu_ready=1, cpu_rdata=mem_rdata; mem_run=0 -> IDLE. Miss latency = MEM_LATENCY+1 cycles.
- WRITE (1 cycle): mem_run=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata; cpu_ready=1. Hit -> data[index] updated. Miss -> no allocate, array unchanged. -> IDLE.
- cpu_ready is high exactly one cycle per request. The controller does not sample cpu_req in the cycle after ready (return to IDLE), so a held req is never double-served. Back-to-back requests: next request is sampled in the IDLE cycle.
- Conflict miss (same index, different tag): the refill overwrites the line; the old line is not written back (write-through keeps RAM coherent).
- cpu_req dropped before ready: illegal. Behaviour is undefined, but the FSM must still return to IDLE.

Optional Feature:
DONGWON_CACHE_STAT_EN: when defined, adds output ports hit_cnt[31:0] and miss_cnt[31:0]. Counters are cleared by reset. hit_cnt increments on entry to READ_HIT. miss_cnt increments on entry to READ_MISS. Both saturate at 32'hFFFF_FFFF. Writes are not counted. When undefined, the ports and logic are absent and the port list is as above.

Test Plan:
- Reset, then read addr 0x0 with RAM[0]=0x0 -> READ_MISS for 1 cycle, REFILL with cpu_ready=1 and cpu_rdata=0x0; no READ_HIT state appears.
- Preload RAM word i = i for i=0..31; read addr 0x00..0x7C, then reread -> first pass is all misses (rdata=i, 2-cycle latency); second pass is all READ_HIT (rdata=i, 1-cycle latency, mem_run stays 0).
- Write 0xDEAD_BEEF to cached addr 0x10 -> WRITE with mem_we=1, mem_addr=0x10; subsequent read hits and returns 0xDEAD_BEEF.
- Write 0x1234 to uncached addr 0x200 -> RAM is written; subsequent read of 0x200 misses and returns 0x1234 after refill.
- Conflict: read 0x0 then 0x100 (same index, CACHE_SIZE=64) then 0x0 -> miss, miss, miss. With DONGWON_CACHE_STAT_EN: miss_cnt=3, hit_cnt=0.
- Assert reset_n=0 during READ_MISS (MEM_LATENCY=3) -> state immediately 000, mem_run=0, cpu_ready never pulses; a subsequent read of any address misses.
